// File: rtl/board_pkg.sv
// board_pkg: shared board-level FSM state type and default timing constants
package board_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PRESSED,
        REPEAT,
        WAIT_RELEASE
    } step_state_t;

    localparam int STEP_SYNC_STAGES   = 2;
    localparam int STEP_HOLD_CYCLES   = 5000;
    localparam int STEP_REPEAT_CYCLES = 1000;

    function automatic int step_cnt_width(input int hold, input int rep);
        return $clog2((hold > rep ? hold : rep) + 1);
    endfunction

endpackage

// File: rtl/sync_chain.sv
// sync_chain: STAGES-deep flop synchronizer for one asynchronous bit
module sync_chain #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    // shift the asynchronous level in, one flop per stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_q <= '0;
        else        sync_q <= {sync_q[STAGES-2:0], d_i};
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/step_pulse_gen.sv
// step_pulse_gen: single-step strobe from a button; define STEP_AUTOREPEAT_EN for hold-to-repeat
module step_pulse_gen
    import board_pkg::*;
#(
    parameter int SYNC_STAGES   = STEP_SYNC_STAGES,
    parameter int HOLD_CYCLES   = STEP_HOLD_CYCLES,
    parameter int REPEAT_CYCLES = STEP_REPEAT_CYCLES
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       debounced_button,
    input  logic       enable,
    output logic       step_pulse,
    output logic       held,
    output logic [7:0] press_count
);

    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
        $error("step_pulse_gen: SYNC_STAGES must be 2..4");
    end
    if (HOLD_CYCLES < 2 || REPEAT_CYCLES < 2) begin : g_bad_timing
        $error("step_pulse_gen: HOLD_CYCLES and REPEAT_CYCLES must be >= 2");
    end

    logic        btn_s;
    step_state_t state_q, state_d;
    logic        fire_q, fire_d;
    logic        step_pulse_q, step_pulse_d;
    logic [7:0]  press_count_q, press_count_d;

`ifdef STEP_AUTOREPEAT_EN
    localparam int CNT_W = step_cnt_width(HOLD_CYCLES, REPEAT_CYCLES);
    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

    sync_chain #(.STAGES(SYNC_STAGES)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (debounced_button),
        .q_o   (btn_s)
    );

    // next state; fire_d marks a transition that earns a strobe one cycle later
    always_comb begin
        state_d = state_q;
        fire_d  = 1'b0;
`ifdef STEP_AUTOREPEAT_EN
        cnt_d   = '0;
`endif
        if (!enable) begin
            state_d = btn_s ? WAIT_RELEASE : IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = btn_s ? PRESSED : IDLE;
                    fire_d  = btn_s;
                end
`ifdef STEP_AUTOREPEAT_EN
                PRESSED: begin
                    state_d = !btn_s ? IDLE : (cnt_q == HOLD_LAST) ? REPEAT : PRESSED;
                    fire_d  = btn_s && cnt_q == HOLD_LAST;
                    cnt_d   = (btn_s && cnt_q != HOLD_LAST) ? cnt_q + CNT_W'(1) : '0;
                end
                REPEAT: begin
                    state_d = btn_s ? REPEAT : IDLE;
                    fire_d  = btn_s && cnt_q == REPEAT_LAST;
                    cnt_d   = (btn_s && cnt_q != REPEAT_LAST) ? cnt_q + CNT_W'(1) : '0;
                end
`else
                PRESSED: state_d = btn_s ? PRESSED : IDLE;
`endif
                WAIT_RELEASE: state_d = btn_s ? WAIT_RELEASE : IDLE;
                default:      state_d = IDLE;
            endcase
        end
    end

    assign step_pulse_d  = fire_q && enable && (state_q == PRESSED || state_q == REPEAT);
    assign press_count_d = press_count_q + 8'(step_pulse_d);

    // state, strobe and counters; reset clears everything immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            fire_q        <= 1'b0;
            step_pulse_q  <= 1'b0;
            press_count_q <= '0;
`ifdef STEP_AUTOREPEAT_EN
            cnt_q         <= '0;
`endif
        end else begin
            state_q       <= state_d;
            fire_q        <= fire_d;
            step_pulse_q  <= step_pulse_d;
            press_count_q <= press_count_d;
`ifdef STEP_AUTOREPEAT_EN
            cnt_q         <= cnt_d;
`endif
        end
    end

    assign step_pulse  = step_pulse_q;
    assign held        = state_q == PRESSED || state_q == REPEAT;
    assign press_count = press_count_q;

endmodule

// File: tb/tb_step_pulse_gen.sv
// tb_step_pulse_gen: randomized and directed checks of step_pulse_gen against a press/age reference model
module tb_step_pulse_gen;

    localparam int SYNC = 2;
    localparam int HOLD = 8;
    localparam int REP  = 4;
`ifdef STEP_AUTOREPEAT_EN
    localparam bit AR = 1'b1;
`else
    localparam bit AR = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       btn = 1'b0;
    logic       en = 1'b1;
    logic       step_pulse, held;
    logic [7:0] press_count;

    typedef struct {
        int         c;
        logic [7:0] pc;
    } exp_t;

    exp_t       sbq[$];
    bit         sh[$];
    int         cyc = 0;
    int         age = 0;
    int         n_chk = 0;
    int         fails = 0;
    bit         act = 1'b0;
    bit         blk = 1'b0;
    bit         fire_prev = 1'b0;
    bit         prev_pulse = 1'b0;
    logic [7:0] mcount = '0;

    step_pulse_gen #(
        .SYNC_STAGES   (SYNC),
        .HOLD_CYCLES   (HOLD),
        .REPEAT_CYCLES (REP)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .debounced_button (btn),
        .enable           (en),
        .step_pulse       (step_pulse),
        .held             (held),
        .press_count      (press_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] a, input logic [31:0] e);
        n_chk++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, a, e);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic hold_btn(input int n);
        btn = 1'b1;
        repeat (n) @(negedge clk);
        btn = 1'b0;
    endtask

    // Reference model: button seen SYNC edges late; a press "ages" one per edge while held,
    // striking at age 0, then HOLD, then every REP after that (auto-repeat builds only).
    // A strike shows as a pulse one edge later if enable is still high then.
    initial begin
        bit bs, f;
        for (int i = 0; i < SYNC; i++) sh.push_back(1'b0);
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                act = 1'b0; blk = 1'b0; fire_prev = 1'b0; age = 0; mcount = '0;
                sbq.delete();
                sh.delete();
                for (int i = 0; i < SYNC; i++) sh.push_back(1'b0);
            end else begin
                cyc++;
                bs = sh.pop_front();
                sh.push_back(btn);
                if (fire_prev && en) begin
                    mcount++;
                    sbq.push_back('{cyc, mcount});
                end
                f = 1'b0;
                if (!en) begin
                    act = 1'b0;
                    blk = bs;
                end else if (act) begin
                    if (!bs) act = 1'b0;
                    else begin
                        age++;
                        f = AR && (age == HOLD || (age > HOLD && (age - HOLD) % REP == 0));
                    end
                end else if (blk) begin
                    blk = bs;
                end else if (bs) begin
                    act = 1'b1;
                    age = 0;
                    f = 1'b1;
                end
                fire_prev = f;
            end
        end
    end

    // Monitor: pops the scoreboard whenever the DUT strobes, flags missing strobes and held errors
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (step_pulse === 1'b1) begin
                    n_chk++;
                    if (sbq.size() == 0) begin
                        fails++;
                        $display("FAIL unexpected_pulse: pulse at cycle %0d, none expected", cyc);
                    end else begin
                        e = sbq.pop_front();
                        if (e.c != cyc || e.pc !== press_count) begin
                            fails++;
                            $display("FAIL pulse_match: got cycle %0d count %0d expected cycle %0d count %0d",
                                     cyc, press_count, e.c, e.pc);
                        end
                    end
                    n_chk++;
                    if (prev_pulse) begin
                        fails++;
                        $display("FAIL double_pulse: step_pulse high two cycles at cycle %0d", cyc);
                    end
                end else if (sbq.size() != 0 && sbq[0].c <= cyc) begin
                    n_chk++;
                    fails++;
                    $display("FAIL missing_pulse: got none at cycle %0d expected pulse at cycle %0d", cyc, sbq[0].c);
                    void'(sbq.pop_front());
                end
                n_chk++;
                if (held !== act) begin
                    fails++;
                    $display("FAIL held: got %b expected %b at cycle %0d", held, act, cyc);
                end
                prev_pulse = (step_pulse === 1'b1);
            end else begin
                prev_pulse = 1'b0;
            end
        end
    end

    // Stimulus
    initial begin
        int lat, pc0, n;
        bit seen;
        rst_n = 1'b0; btn = 1'b0; en = 1'b1;
        idle(3);
        check("reset_step_pulse", step_pulse, 0);
        check("reset_held", held, 0);
        check("reset_press_count", press_count, 0);
        #2 rst_n = 1'b1;
        idle(4);

        // 3-cycle press: first strobe 4 cycles after input rise
        lat = 0; seen = 1'b0; btn = 1'b1;
        for (int i = 1; i <= 20 && !seen; i++) begin
            @(negedge clk);
            if (i == 3) btn = 1'b0;
            if (step_pulse === 1'b1) begin seen = 1'b1; lat = i; end
        end
        btn = 1'b0;
        check("first_pulse_latency", lat, 4);
        idle(10);
        check("single_press_count", press_count, 1);

        // 20-cycle hold
        pc0 = press_count;
        hold_btn(20);
        idle(10);
        check("hold20_pulses", 8'(press_count - pc0), AR ? 4 : 1);

        // 40-cycle hold
        pc0 = press_count;
        hold_btn(40);
        idle(10);
        check("hold40_pulses", 8'(press_count - pc0), AR ? 9 : 1);

        // enable dropped while held, raised again before release
        btn = 1'b1;
        idle(6);
        en = 1'b0;
        idle(5);
        en = 1'b1;
        pc0 = press_count;
        idle(10);
        check("no_pulse_after_enable_rise", press_count, pc0);
        check("held_low_in_wait_release", held, 0);
        btn = 1'b0;
        idle(6);
        pc0 = press_count;
        hold_btn(3);
        idle(8);
        check("repress_after_wait", 8'(press_count - pc0), 1);

        // randomized presses with enable glitches
        for (int k = 0; k < 40; k++) begin
            n = $urandom_range(1, 30);
            btn = 1'b1;
            repeat (n) begin
                en = ($urandom_range(0, 7) != 0);
                @(negedge clk);
            end
            btn = 1'b0;
            n = $urandom_range(1, 8);
            repeat (n) begin
                en = ($urandom_range(0, 7) != 0);
                @(negedge clk);
            end
        end
        en = 1'b1;
        idle(10);

        // async reset deep into a long hold, button kept down through it
        btn = 1'b1;
        idle(30);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_step_pulse", step_pulse, 0);
        check("async_reset_held", held, 0);
        check("async_reset_press_count", press_count, 0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        lat = 0; seen = 1'b0;
        for (int i = 1; i <= 20 && !seen; i++) begin
            @(negedge clk);
            if (step_pulse === 1'b1) begin seen = 1'b1; lat = i; end
        end
        check("post_reset_latency", lat, 4);
        check("post_reset_count", press_count, 1);
        btn = 1'b0;
        idle(10);

        // 256 presses from a clean count wrap to zero, the 257th gives one
        rst_n = 1'b0;
        idle(2);
        #2 rst_n = 1'b1;
        idle(4);
        repeat (256) begin
            hold_btn(2);
            idle(4);
        end
        idle(4);
        check("wrap_256", press_count, 0);
        hold_btn(2);
        idle(8);
        check("count_257", press_count, 1);

        idle(10);
        check("scoreboard_drained", sbq.size(), 0);
        check("model_count", press_count, mcount);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, fails);
        $finish;
    end

endmodule
